serial_adder: RTL and testbench

//  Bit-serial ripple adder: accepts two WIDTH-bit operands and a carry-in, then adds one
//  bit per clock, LSB first, through a single 1-bit full adder built from sheffer (NAND)

---
 rtl/serial_adder_if.sv | 29 ++
 rtl/serial_adder.sv | 139 +++++++++++++
 tb/tb_serial_adder.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/serial_adder_if.sv
// serial_adder_if: operand/result handshake bundle for the bit-serial adder.
//   in_valid/in_ready  : operand handshake (a, b, cin)
//   out_valid/out_ready: result handshake (sum, cout)
//   busy               : adder is currently rippling bits
// master = the producer/consumer side, slave = the adder itself.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, busy
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, busy
  );
endinterface

// File: rtl/serial_adder.sv
// serial_adder: bit-serial ripple adder. Operands are latched on accept, then
// one bit per clock (LSB first) passes through a single NAND-only full adder
// with a registered carry. Result is presented after exactly WIDTH RUN cycles
// and held until the consumer takes it.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    serial_adder_if.slave: in_valid/in_ready/a/b/cin,
//          out_valid/out_ready/sum/cout, busy
//
// sheffer      : 2-input NAND primitive
// sa_fa_nand   : 1-bit full adder built from nine sheffer gates

module sheffer (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = ~(a & b);
endmodule

module sa_fa_nand (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  logic n1, n2, n3, axb, n5, n6, n7;

  // a ^ b from four NANDs; n1 = ~(a&b) is reused for the carry
  sheffer u_n1 (.a(a),   .b(b),  .y(n1));
  sheffer u_n2 (.a(a),   .b(n1), .y(n2));
  sheffer u_n3 (.a(b),   .b(n1), .y(n3));
  sheffer u_n4 (.a(n2),  .b(n3), .y(axb));
  // (a^b) ^ ci; n5 = ~((a^b)&ci) is reused for the carry
  sheffer u_n5 (.a(axb), .b(ci), .y(n5));
  sheffer u_n6 (.a(axb), .b(n5), .y(n6));
  sheffer u_n7 (.a(ci),  .b(n5), .y(n7));
  sheffer u_n8 (.a(n6),  .b(n7), .y(s));
  // co = (a&b) | ((a^b)&ci)
  sheffer u_n9 (.a(n5),  .b(n1), .y(co));
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  serial_adder_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic [WIDTH-1:0] sum_q, sum_shift;
  logic             carry_q, cout_q;
  logic             fa_s, fa_co;
  logic             last_bit;

  sa_fa_nand u_fa (
    .a  (a_sh[0]),
    .b  (b_sh[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  assign last_bit = (cnt_q == CW'(WIDTH - 1));

  // New sum bit enters at the MSB so after WIDTH shifts bit 0 holds the LSB.
  always_comb begin
    sum_shift            = sum_q >> 1;
    sum_shift[WIDTH-1]   = fa_s;
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid) state_d = RUN;
      RUN:     if (last_bit)     state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sh    <= '0;
      b_sh    <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            a_sh    <= bus.a;
            b_sh    <= bus.b;
            carry_q <= bus.cin;
            cnt_q   <= '0;
          end
        end
        RUN: begin
          a_sh    <= a_sh >> 1;
          b_sh    <= b_sh >> 1;
          carry_q <= fa_co;
          sum_q   <= sum_shift;
          cnt_q   <= cnt_q + CW'(1);
          if (last_bit) cout_q <= fa_co;
        end
        default: ;  // DONE holds sum/cout for backpressure
      endcase
    end
  end

  // Status decoded from registered state only.
  assign bus.in_ready  = (state_q == IDLE);
  assign bus.busy      = (state_q == RUN);
  assign bus.out_valid = (state_q == DONE);
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   passed = 0;
  int   total  = 0;

  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(8)) b8 ();
  serial_adder_if #(.WIDTH(4)) b4 ();

  serial_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(b8));
  serial_adder #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4));

  // inputs change and outputs are sampled 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer addition of the operands.
  function automatic logic [8:0] ref8(input logic [7:0] a, input logic [7:0] b, input logic c);
    return {1'b0, a} + {1'b0, b} + {8'd0, c};
  endfunction

  // Issue one 8-bit operation, check RUN length and result; optionally drain.
  task automatic run8(input string nm, input logic [7:0] ta, input logic [7:0] tb_,
                      input logic tc, input bit drain);
    logic [8:0] exp;
    exp = ref8(ta, tb_, tc);
    total++;
    if (b8.in_ready !== 1'b1) $display("FAIL %s idle: in_ready=%b expected 1", nm, b8.in_ready);
    else passed++;
    b8.a = ta; b8.b = tb_; b8.cin = tc; b8.in_valid = 1'b1; b8.out_ready = 1'b0;
    tick();
    // operand changes after accept must not matter
    b8.in_valid = 1'b0;
    b8.a = 8'($urandom); b8.b = 8'($urandom); b8.cin = 1'($urandom);
    for (int i = 1; i <= 8; i++) begin
      total++;
      if (b8.busy !== 1'b1 || b8.out_valid !== 1'b0 || b8.in_ready !== 1'b0)
        $display("FAIL %s run%0d: busy=%b out_valid=%b in_ready=%b expected 1/0/0",
                 nm, i, b8.busy, b8.out_valid, b8.in_ready);
      else passed++;
      tick();
    end
    total++;
    if (b8.out_valid !== 1'b1 || b8.busy !== 1'b0)
      $display("FAIL %s latency: out_valid=%b busy=%b expected 1/0", nm, b8.out_valid, b8.busy);
    else passed++;
    total++;
    if ({b8.cout, b8.sum} !== exp)
      $display("FAIL %s result: cout,sum=%h expected %h", nm, {b8.cout, b8.sum}, exp);
    else passed++;
    if (drain) begin
      b8.out_ready = 1'b1;
      tick();
      b8.out_ready = 1'b0;
      total++;
      if (b8.in_ready !== 1'b1 || b8.out_valid !== 1'b0)
        $display("FAIL %s drain: in_ready=%b out_valid=%b expected 1/0", nm, b8.in_ready, b8.out_valid);
      else passed++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    b8.in_valid = 1'b1; b8.a = 8'hAA; b8.b = 8'h55; b8.cin = 1'b1; b8.out_ready = 1'b0;
    b4.in_valid = 1'b0; b4.a = '0; b4.b = '0; b4.cin = 1'b0; b4.out_ready = 1'b1;
    tick(); tick();
    total++;
    if (b8.in_ready !== 1'b1 || b8.out_valid !== 1'b0 || b8.busy !== 1'b0 ||
        b8.sum !== 8'h00 || b8.cout !== 1'b0)
      $display("FAIL reset: rdy=%b vld=%b busy=%b sum=%h cout=%b expected 1/0/0/00/0",
               b8.in_ready, b8.out_valid, b8.busy, b8.sum, b8.cout);
    else passed++;
    b8.in_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    total++;
    if (b8.in_ready !== 1'b1 || b8.busy !== 1'b0)
      $display("FAIL idle_hold: in_ready=%b busy=%b expected 1/0", b8.in_ready, b8.busy);
    else passed++;
  endtask

  task automatic test_directed();
    run8("add_03_05", 8'h03, 8'h05, 1'b0, 1'b1);
    run8("wrap_ff_01", 8'hFF, 8'h01, 1'b0, 1'b1);
    run8("all_ones_cin", 8'hFF, 8'hFF, 1'b1, 1'b1);
  endtask

  task automatic test_backpressure();
    run8("bp_10_20", 8'h10, 8'h20, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      b8.in_valid = i[0];
      b8.a = 8'($urandom); b8.b = 8'($urandom);
      tick();
      total++;
      if (b8.out_valid !== 1'b1 || b8.in_ready !== 1'b0 || b8.sum !== 8'h30 || b8.cout !== 1'b0)
        $display("FAIL bp_hold%0d: vld=%b rdy=%b sum=%h cout=%b expected 1/0/30/0",
                 i, b8.out_valid, b8.in_ready, b8.sum, b8.cout);
      else passed++;
    end
    // handshake edge with in_valid high: must not accept in the same cycle
    b8.in_valid = 1'b1;
    b8.out_ready = 1'b1;
    tick();
    b8.out_ready = 1'b0;
    b8.in_valid = 1'b0;
    total++;
    if (b8.in_ready !== 1'b1 || b8.out_valid !== 1'b0 || b8.busy !== 1'b0 || b8.sum !== 8'h30)
      $display("FAIL bp_release: rdy=%b vld=%b busy=%b sum=%h expected 1/0/0/30",
               b8.in_ready, b8.out_valid, b8.busy, b8.sum);
    else passed++;
    tick();
    total++;
    if (b8.in_ready !== 1'b1 || b8.busy !== 1'b0 || b8.sum !== 8'h30)
      $display("FAIL bp_idle: rdy=%b busy=%b sum=%h expected 1/0/30", b8.in_ready, b8.busy, b8.sum);
    else passed++;
  endtask

  task automatic test_reset_abort();
    b8.a = 8'hC3; b8.b = 8'h5A; b8.cin = 1'b1; b8.in_valid = 1'b1;
    tick();
    b8.in_valid = 1'b0;
    tick(); tick(); tick();
    total++;
    if (b8.busy !== 1'b1)
      $display("FAIL abort_pre: busy=%b expected 1", b8.busy);
    else passed++;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    total++;
    if (b8.out_valid !== 1'b0 || b8.busy !== 1'b0 || b8.in_ready !== 1'b1 ||
        b8.sum !== 8'h00 || b8.cout !== 1'b0)
      $display("FAIL abort: vld=%b busy=%b rdy=%b sum=%h cout=%b expected 0/0/1/00/0",
               b8.out_valid, b8.busy, b8.in_ready, b8.sum, b8.cout);
    else passed++;
    run8("post_abort", 8'h7F, 8'h01, 1'b0, 1'b1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++)
      run8($sformatf("rand%0d", i), 8'($urandom), 8'($urandom), 1'($urandom), 1'b1);
  endtask

  task automatic test_back_to_back_w4();
    logic [3:0] ta, tb_;
    logic       tc;
    int         exp;
    b4.out_ready = 1'b1;
    for (int v = 0; v < 512; v++) begin
      {tc, ta, tb_} = 9'(v);
      exp = int'(ta) + int'(tb_) + int'(tc);
      b4.a = ta; b4.b = tb_; b4.cin = tc; b4.in_valid = 1'b1;
      tick();                               // accept
      b4.a = 4'($urandom); b4.b = 4'($urandom);
      for (int k = 0; k < 4; k++) tick();   // four RUN edges
      total++;
      if (b4.out_valid !== 1'b1 || {b4.cout, b4.sum} !== 5'(exp)) begin
        $display("FAIL w4 a=%h b=%h cin=%b: vld=%b cout,sum=%h expected 1/%h",
                 ta, tb_, tc, b4.out_valid, {b4.cout, b4.sum}, 5'(exp));
        $display("%0d/%0d checks passed", passed, total);
        $fatal(1, "w4 exhaustive mismatch");
      end else passed++;
      tick();                               // output handshake -> IDLE
    end
    b4.in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_abort();
    test_random();
    test_back_to_back_w4();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
